// File: rtl/perf_pkg.sv
// Shared types and constants for the pipeline performance monitor.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } perf_state_e;

  // Event channel assignment used by the CPU hookup.
  localparam int EV_LWSTALL = 0;
  localparam int EV_FLUSH   = 1;

  function automatic int sel_width(input int num_events);
    return $clog2(num_events + 1);
  endfunction

endpackage

// File: rtl/perf_event_counter_sat.sv
// Saturating up-counter with a sticky overflow flag.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] r_cnt;
  logic             r_ovf;
  logic             w_bump;
  logic             w_full;

  assign w_bump = en_i & inc_i;
  assign w_full = &r_cnt;

  // An increment request at all-ones holds the value and latches overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_bump) begin
      if (w_full) r_ovf <= 1'b1;
      else        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;
  assign ovf_o = r_ovf;

endmodule

// File: rtl/perf_event_counter.sv
// Run-cycle and per-event performance counters with limit, pause and readout.
module perf_event_counter
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS = 2,
  parameter int CNT_WIDTH  = 32,
  parameter int SEL_WIDTH  = sel_width(NUM_EVENTS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic [CNT_WIDTH-1:0]  limit_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic [SEL_WIDTH-1:0]  rd_sel_i,
  output logic [CNT_WIDTH-1:0]  rd_data_o,
  output logic [1:0]            state_o,
  output logic                  done_o,
  output logic [NUM_EVENTS:0]   overflow_o
);

  perf_state_e r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_limit;
  logic [CNT_WIDTH-1:0] r_rd;
  logic [CNT_WIDTH-1:0] w_rd;
  logic                 w_latch;
  logic                 w_run;
  logic                 w_hit;
  logic                 w_cnt_en;

  logic [NUM_EVENTS:0][CNT_WIDTH-1:0] w_cnt;
  logic [NUM_EVENTS:0]                w_inc;
  logic [NUM_EVENTS:0]                w_ovf;

  assign w_run = (r_state == ST_RUN);

  // Limit hit is judged on the real post-increment count, so a saturated
  // cycle counter can never fake a match.
  assign w_hit = w_run && (r_limit != '0) && !(&w_cnt[0]) &&
                 ((w_cnt[0] + 1'b1) == r_limit);

  // A pausing cycle is not counted unless it is also the limit cycle.
  assign w_cnt_en = w_run && (start_i || w_hit);

  assign w_inc = {event_i, 1'b1};

  for (genvar g = 0; g <= NUM_EVENTS; g++) begin : g_cnt
    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .en_i  (w_cnt_en),
      .inc_i (w_inc[g]),
      .cnt_o (w_cnt[g]),
      .ovf_o (w_ovf[g])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = ST_RUN;
          w_latch     = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_hit)         w_state_nxt = ST_DONE;
        else if (!start_i) w_state_nxt = ST_IDLE;
      end
      ST_DONE: w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_limit <= '0;
    end else if (clear_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) r_limit <= limit_i;
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    w_rd = '0;
    for (int k = 0; k <= NUM_EVENTS; k++) begin
      if (rd_sel_i == SEL_WIDTH'(k)) w_rd = w_cnt[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) r_rd <= '0;
    else                  r_rd <= w_rd;
  end

  assign rd_data_o  = r_rd;
  assign state_o    = r_state;
  assign done_o     = (r_state == ST_DONE);
  assign overflow_o = w_ovf;

endmodule

// File: tb/tb_perf_event_counter.sv
// Bench for perf_event_counter: 8-bit and 4-bit instances on shared stimulus.
module tb_perf_event_counter;
  import perf_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, clear;
  logic [7:0] limit;
  logic [3:0] limit4;
  logic [1:0] ev, sel;
  logic [7:0] rd8;
  logic [3:0] rd4;
  logic [1:0] st8, st4;
  logic       dn8, dn4;
  logic [2:0] ov8, ov4;

  assign limit4 = limit[3:0];

  perf_event_counter #(.NUM_EVENTS(2), .CNT_WIDTH(8)) u_d8 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .limit_i(limit),
    .event_i(ev), .rd_sel_i(sel), .rd_data_o(rd8), .state_o(st8), .done_o(dn8),
    .overflow_o(ov8));

  perf_event_counter #(.NUM_EVENTS(2), .CNT_WIDTH(4)) u_d4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .limit_i(limit4),
    .event_i(ev), .rd_sel_i(sel), .rd_data_o(rd4), .state_o(st4), .done_o(dn4),
    .overflow_o(ov4));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: plain integer counters per instance, 0=IDLE 1=RUN 2=DONE.
  int       m_cnt[2][3];
  int       m_st[2];
  int       m_lim[2];
  int       m_rd[2];
  bit [2:0] m_ovf[2];
  int       maxv[2] = '{255, 15};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit hit, inc;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int k = 0; k < 3; k++) m_cnt[d][k] = 0;
        m_ovf[d] = '0; m_st[d] = 0; m_lim[d] = 0; m_rd[d] = 0;
      end else if (clear) begin
        for (int k = 0; k < 3; k++) m_cnt[d][k] = 0;
        m_ovf[d] = '0; m_st[d] = 0; m_rd[d] = 0;
      end else begin
        m_rd[d] = (int'(sel) <= 2) ? m_cnt[d][int'(sel)] : 0;
        if (m_st[d] == 0) begin
          if (start) begin
            m_st[d]  = 1;
            m_lim[d] = int'(limit) & maxv[d];
          end
        end else if (m_st[d] == 1) begin
          hit = (m_lim[d] != 0) && (m_cnt[d][0] + 1 == m_lim[d]);
          if (start || hit) begin
            for (int k = 0; k < 3; k++) begin
              inc = (k == 0) ? 1'b1 : ev[k-1];
              if (inc) begin
                if (m_cnt[d][k] == maxv[d]) m_ovf[d][k] = 1'b1;
                else                        m_cnt[d][k]++;
              end
            end
          end
          if (hit)         m_st[d] = 2;
          else if (!start) m_st[d] = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("m8.rd", rd8, m_rd[0]);   chk("m8.state", st8, m_st[0]);
    chk("m8.done", dn8, m_st[0] == 2); chk("m8.ovf", ov8, m_ovf[0]);
    chk("m4.rd", rd4, m_rd[1]);   chk("m4.state", st4, m_st[1]);
    chk("m4.done", dn4, m_st[1] == 2); chk("m4.ovf", ov4, m_ovf[1]);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic rd_chk(input int s, input int exp8, input string name);
    sel = 2'(s);
    tick();
    chk(name, rd8, exp8);
  endtask

  typedef struct {
    logic       start;
    logic       clear;
    logic [1:0] ev;
    logic [1:0] sel;
    logic [7:0] exp_rd;
    logic [1:0] exp_st;
  } vec_t;
  vec_t tbl[$];

  initial begin
    logic [7:0] prev;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) m_cnt[d][k] = 0;
      m_ovf[d] = '0; m_st[d] = 0; m_lim[d] = 0; m_rd[d] = 0;
    end
    rst = 1'b1; start = 1'b0; clear = 1'b0; limit = '0; ev = '0; sel = '0;
    tick(); tick();
    chk("reset.rd", rd8, 0); chk("reset.state", st8, 0);
    chk("reset.done", dn8, 0); chk("reset.ovf", ov8, 0);

    // Basic limit run
    rst = 1'b0; limit = 8'd10; start = 1'b1;
    tick();
    chk("basic.enter_run", st8, 1);
    for (int i = 0; i < 10; i++) begin
      ev = '0;
      ev[EV_LWSTALL] = 1'b1;
      ev[EV_FLUSH]   = (i == 2 || i == 5 || i == 7);
      tick();
    end
    chk("basic.state", st8, 2); chk("basic.done", dn8, 1); chk("basic.done4", dn4, 1);
    ev = '0;
    rd_chk(0, 10, "basic.cycle"); rd_chk(1, 10, "basic.ch0"); rd_chk(2, 3, "basic.ch1");
    ev = 2'b11;
    for (int i = 0; i < 5; i++) tick();
    ev = '0;
    rd_chk(0, 10, "basic.cycle_hold"); rd_chk(1, 10, "basic.ch0_hold");
    rd_chk(2, 3, "basic.ch1_hold");    chk("basic.done_hold", dn8, 1);

    // Clear priority over start and events
    clear = 1'b1; start = 1'b0; tick(); clear = 1'b0;
    limit = 8'd0; start = 1'b1; tick();
    ev = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear.state", st8, 0); chk("clear.rd", rd8, 0); chk("clear.ovf", ov8, 0);
    tick();
    chk("clear.restart", st8, 1);
    start = 1'b0; tick();
    rd_chk(0, 0, "clear.cycle"); rd_chk(1, 0, "clear.ch0");

    // Pause/resume
    sel = 2'd2; start = 1'b1; ev = '0; tick();
    ev = 2'b01; for (int i = 0; i < 4; i++) tick();
    start = 1'b0; ev = 2'b11; for (int i = 0; i < 5; i++) tick();
    chk("pause.state", st8, 0);
    start = 1'b1; ev = '0; tick();
    ev = 2'b01; for (int i = 0; i < 3; i++) tick();
    start = 1'b0; ev = '0; tick();

    // Readout table: cycle=7, ch0=7, ch1=0
    tbl.push_back('{1'b0, 1'b0, 2'b11, 2'd2, 8'd0, 2'd0});
    tbl.push_back('{1'b0, 1'b0, 2'b00, 2'd1, 8'd7, 2'd0});
    tbl.push_back('{1'b0, 1'b0, 2'b01, 2'd3, 8'd0, 2'd0});
    tbl.push_back('{1'b0, 1'b0, 2'b10, 2'd0, 8'd7, 2'd0});
    tbl.push_back('{1'b0, 1'b0, 2'b00, 2'd2, 8'd0, 2'd0});
    tbl.push_back('{1'b0, 1'b1, 2'b11, 2'd0, 8'd0, 2'd0});
    tbl.push_back('{1'b0, 1'b0, 2'b00, 2'd0, 8'd0, 2'd0});
    prev = 8'd0;
    foreach (tbl[i]) begin
      start = tbl[i].start; clear = tbl[i].clear; ev = tbl[i].ev; sel = tbl[i].sel;
      #1;
      chk($sformatf("vec%0d.pre_rd", i), rd8, prev);
      tick();
      chk($sformatf("vec%0d.rd", i), rd8, tbl[i].exp_rd);
      chk($sformatf("vec%0d.state", i), st8, tbl[i].exp_st);
      prev = tbl[i].exp_rd;
    end
    clear = 1'b0;

    // Saturation on the 4-bit instance
    limit = 8'd0; start = 1'b1; ev = '0; sel = 2'd0; tick();
    ev = 2'b01; for (int i = 0; i < 20; i++) tick();
    chk("sat.state4", st4, 1); chk("sat.ovf4", ov4, 3'b011); chk("sat.cycle4", rd4, 15);
    chk("sat.cycle8", rd8, 19); chk("sat.ovf8", ov8, 0);
    sel = 2'd1; tick();
    chk("sat.ch0_4", rd4, 15); chk("sat.ch0_8", rd8, 20); chk("sat.run4", st4, 1);

    // Mid-run reset
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; ev = 2'b01; sel = 2'd0; tick();
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; tick();
    chk("rst.rd8", rd8, 0); chk("rst.state8", st8, 0); chk("rst.done8", dn8, 0);
    chk("rst.ovf8", ov8, 0); chk("rst.rd4", rd4, 0); chk("rst.ovf4", ov4, 0);
    rst = 1'b0; start = 1'b0; tick();
    chk("rst.idle", st8, 0);
    rd_chk(0, 0, "rst.no_count");
    start = 1'b1; tick(); chk("rst.rerun", st8, 1);
    tick(); chk("rst.first_rd", rd8, 0);
    tick(); chk("rst.second_rd", rd8, 1);

    // Random mix: short runs with frequent control changes
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      clear = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 9) != 0);
      ev    = 2'($urandom);
      sel   = 2'($urandom);
      if ($urandom_range(0, 15) == 0) limit = 8'($urandom_range(0, 40));
      tick();
    end
    // Long free runs to saturate the 8-bit instance
    rst = 1'b0; clear = 1'b0; limit = 8'd0;
    for (int i = 0; i < 700; i++) begin
      start = ($urandom_range(0, 49) != 0);
      ev    = 2'($urandom);
      sel   = 2'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
